ex_muldiv: RTL and testbench

//   Multi-cycle HI/LO execute unit in the EX stage, directly downstream of the ID/EX register.

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/ex_muldiv_div_iter.sv | 63 ++++++
 rtl/ex_muldiv.sv | 134 +++++++++++++
 tb/tb_ex_muldiv.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared cpu types for the HI/LO execute unit: op encoding, FSM state constants, width.
package ex_muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MADD  = 4'd3,
    MD_MADDU = 4'd4,
    MD_MSUB  = 4'd5,
    MD_MSUBU = 4'd6,
    MD_DIV   = 4'd7,
    MD_DIVU  = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } muldiv_op_e;

  typedef logic [1:0] md_state_e;
  localparam md_state_e ST_IDLE = 2'd0;
  localparam md_state_e ST_MUL  = 2'd1;
  localparam md_state_e ST_DIV  = 2'd2;

  function automatic logic md_is_signed(muldiv_op_e op);
    return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle for XLEN cycles.
// done is combinational during the final bit; quotient/remainder are valid alongside it.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_n, quo_n;

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder, quotient bits enter at the LSB
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign done      = run_q && (cnt_q == LAST);
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (run_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO; stalls ID/EX while a multi-cycle op runs.
// Operands are read straight from ID/EX, which stays frozen while stall_req_o is high.
module ex_muldiv #(
  parameter int XLEN       = ex_muldiv_pkg::XLEN,
  parameter int MUL_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  ex_muldiv_pkg::muldiv_op_e op_i,
  input  logic [XLEN-1:0]          a_i,
  input  logic [XLEN-1:0]          b_i,
  input  logic                     flush_i,
  output logic                     stall_req_o,
  output logic                     busy_o,
  output logic [XLEN-1:0]          hi_o,
  output logic [XLEN-1:0]          lo_o
);
  import ex_muldiv_pkg::*;

  localparam int W2 = 2 * XLEN;
  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);

  md_state_e       state_q;
  logic [7:0]      mcnt_q;
  muldiv_op_e      op_q;
  logic [W2-1:0]   prod_q, prod_c, a_ext, b_ext;
  logic [XLEN-1:0] hi_q, lo_q, a_mag, b_mag, div_quo, div_rem;
  logic            neg_quo_q, neg_rem_q;
  logic            sgn, is_mul, is_div, b_zero, issue, div_start, div_done, stall_c;

  function automatic logic [W2-1:0] accum(muldiv_op_e op, logic [W2-1:0] acc, logic [W2-1:0] p);
    case (op)
      MD_MADD, MD_MADDU: return acc + p;
      MD_MSUB, MD_MSUBU: return acc - p;
      default:           return p;
    endcase
  endfunction

  assign sgn    = md_is_signed(op_i);
  assign is_mul = (op_i == MD_MULT) || (op_i == MD_MULTU) || (op_i == MD_MADD) ||
                  (op_i == MD_MADDU) || (op_i == MD_MSUB) || (op_i == MD_MSUBU);
  assign is_div = (op_i == MD_DIV) || (op_i == MD_DIVU);
  assign b_zero = (b_i == '0);
  assign issue  = valid_i && (state_q == ST_IDLE) && !flush_i;

  // Low half of a 2*XLEN product is the same for signed and unsigned once operands are extended
  assign a_ext  = sgn ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
  assign b_ext  = sgn ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
  assign prod_c = a_ext * b_ext;

  assign a_mag     = (sgn && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag     = (sgn && b_i[XLEN-1]) ? -b_i : b_i;
  assign div_start = issue && is_div && !b_zero;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: stall_c = issue && ((is_mul && (MUL_CYCLES > 1)) || (is_div && !b_zero));
      ST_MUL:  stall_c = (mcnt_q < MUL_LAST);
      ST_DIV:  stall_c = !div_done;
      default: stall_c = 1'b0;
    endcase
  end

  assign stall_req_o = stall_c && !flush_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcnt_q    <= '0;
      op_q      <= MD_NONE;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (issue) begin
          if (op_i == MD_MTHI) hi_q <= a_i;
          if (op_i == MD_MTLO) lo_q <= a_i;
          if (is_mul) begin
            if (MUL_CYCLES == 1) begin
              {hi_q, lo_q} <= accum(op_i, {hi_q, lo_q}, prod_c);
            end else begin
              state_q <= ST_MUL;
              mcnt_q  <= 8'd1;
              op_q    <= op_i;
              prod_q  <= prod_c;
            end
          end
          if (is_div && !b_zero) begin
            state_q   <= ST_DIV;
            neg_quo_q <= sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            neg_rem_q <= sgn && a_i[XLEN-1];
          end
        end
        ST_MUL: begin
          if (mcnt_q == MUL_LAST) begin
            {hi_q, lo_q} <= accum(op_q, {hi_q, lo_q}, prod_q);
            state_q      <= ST_IDLE;
          end else begin
            mcnt_q <= mcnt_q + 8'd1;
          end
        end
        ST_DIV: if (div_done) begin
          lo_q    <= neg_quo_q ? -div_quo : div_quo;
          hi_q    <= neg_rem_q ? -div_rem : div_rem;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic HI/LO reference model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  muldiv_op_e  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_req_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi, mlo;

  ex_muldiv #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op on {mhi,mlo}; returns the number of stall cycles it should cost
  task automatic model(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output int exp_stall);
    longint sa, sb, q, r;
    logic [63:0] p, acc, res;
    exp_stall = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = {mhi, mlo};
    case (op)
      MD_MTHI: mhi = a;
      MD_MTLO: mlo = a;
      MD_MULT, MD_MADD, MD_MSUB, MD_MULTU, MD_MADDU, MD_MSUBU: begin
        if (op == MD_MULT || op == MD_MADD || op == MD_MSUB) p = 64'(sa * sb);
        else p = {32'd0, a} * {32'd0, b};
        if (op == MD_MADD || op == MD_MADDU) res = acc + p;
        else if (op == MD_MSUB || op == MD_MSUBU) res = acc - p;
        else res = p;
        {mhi, mlo} = res;
        exp_stall = 1;
      end
      MD_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        mlo = q[31:0];
        mhi = r[31:0];
        exp_stall = 32;
      end
      MD_DIVU: if (b != 0) begin
        mlo = a / b;
        mhi = a % b;
        exp_stall = 32;
      end
      default: ;
    endcase
  endtask

  // Caller is at a negedge; returns one negedge after the op's final (non-stalled) cycle
  task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    int exp_stall, stalls;
    model(op, a, b, exp_stall);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    stalls = 0;
    #1;
    while (stall_req_o && stalls < 64) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check($sformatf("stall_cycles_%s", op.name()), 64'(stalls), 64'(exp_stall));
    @(negedge clk);
    check($sformatf("hi_%s", op.name()), {32'd0, hi_o}, {32'd0, mhi});
    check($sformatf("lo_%s", op.name()), {32'd0, lo_o}, {32'd0, mlo});
  endtask

  task automatic gap();
    valid_i = 1'b0; op_i = MD_NONE;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Abort a DIVU at count=10 with either flush or reset
  task automatic abort_div(input bit use_rst);
    valid_i = 1'b1; op_i = MD_DIVU; a_i = 32'd1000; b_i = 32'd7;
    #1;
    check("abort_issue_stall", {63'd0, stall_req_o}, 64'd1);
    repeat (11) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush_i = 1'b1;
    #1;
    if (!use_rst) check("flush_stall_low", {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = MD_NONE;
    if (use_rst) begin mhi = 0; mlo = 0; end
    #1;
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_stall", {63'd0, stall_req_o}, 64'd0);
    check("abort_hi", {32'd0, hi_o}, {32'd0, mhi});
    check("abort_lo", {32'd0, lo_o}, {32'd0, mlo});
    @(negedge clk);
  endtask

  muldiv_op_e ops[11] = '{MD_NONE, MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB,
                          MD_MSUBU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = MD_NONE; a_i = '0; b_i = '0; flush_i = 1'b0;
    mhi = '0; mlo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hi", {32'd0, hi_o}, 64'd0);
    check("reset_lo", {32'd0, lo_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_stall", {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg_hi_const", {32'd0, hi_o}, 64'h0000_0000_FFFF_FFFF);
    check("mult_neg_lo_const", {32'd0, lo_o}, 64'h0000_0000_FFFF_FFFA);
    gap();
    run_op(MD_MTHI, 32'h1234_5678, 32'd0);
    run_op(MD_MTLO, 32'd1, 32'd0);
    run_op(MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    gap();
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", {32'd0, lo_o}, 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi_const", {32'd0, hi_o}, 64'h0000_0000_FFFF_FFFF);
    run_op(MD_DIVU, 32'd100, 32'd0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", {32'd0, lo_o}, 64'h0000_0000_8000_0000);
    check("div_ovf_hi_const", {32'd0, hi_o}, 64'd0);
    run_op(MD_MTHI, 32'hCAFE_0001, 32'd0);
    abort_div(1'b0);
    abort_div(1'b1);
    // back-to-back with valid held across the boundary
    run_op(MD_MULT, 32'd12345, 32'hFFFF_0000);
    run_op(MD_DIV, 32'h7654_3210, 32'hFFFF_FF03);
    run_op(MD_MSUB, 32'h0000_0010, 32'h8000_0000);

    for (int i = 0; i < 200; i++) begin
      run_op(ops[$urandom_range(0, 10)], rnd_val(), rnd_val());
      if ($urandom_range(0, 3) == 0) gap();
    end

    gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
